// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front end.
//   spi_state_e - FSM states of the slave
//   SPI_RX_W    - frame width delivered to the RAM (2-bit opcode + 8-bit payload)
//   SPI_TX_W    - read-data width returned by the RAM
//   OP_*        - opcode values carried in rx_data[9:8]; decoded by the RAM, not here
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    localparam int SPI_RX_W = 10;
    localparam int SPI_TX_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer: loads one RAM read byte per frame and shifts it out MSB first.
//   clk        - SPI serial clock, rising edge
//   rst        - synchronous active-high reset
//   clr_i      - frame end (chip select high): abort output, re-arm the load
//   load_en_i  - a READ_DATA frame has completed; tx_valid may now load
//   tx_data_i  - RAM read data
//   tx_valid_i - RAM read data valid
//   miso_o     - registered serial output, 0 when idle
module spi_tx_serializer #(
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            load_en_i,
    input  logic [TX_W-1:0] tx_data_i,
    input  logic            tx_valid_i,
    output logic            miso_o
);

    localparam int CNT_W = $clog2(TX_W);

    logic [TX_W-1:0]  tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
    logic             loaded_q,   loaded_d;
    logic             miso_q,     miso_d;

    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        loaded_d   = loaded_q;
        miso_d     = 1'b0;
        if (clr_i) begin
            tx_cnt_d = '0;
            loaded_d = 1'b0;
        end else if (load_en_i && tx_valid_i && !loaded_q) begin
            // MSB goes out on the load edge itself; the remaining bits follow.
            miso_d     = tx_data_i[TX_W-1];
            tx_shift_d = {tx_data_i[TX_W-2:0], 1'b0};
            tx_cnt_d   = CNT_W'(TX_W - 1);
            loaded_d   = 1'b1;
        end else if (tx_cnt_q != '0) begin
            miso_d     = tx_shift_q[TX_W-1];
            tx_shift_d = {tx_shift_q[TX_W-2:0], 1'b0};
            tx_cnt_d   = tx_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            loaded_q   <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            loaded_q   <= loaded_d;
            miso_q     <= miso_d;
        end
    end

    assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI serial front end of the SPI-to-RAM path.
//   clk      - SPI serial clock, all logic on rising edge
//   rst      - synchronous active-high reset
//   SS_n     - chip select, active low
//   MOSI     - serial data in, MSB first
//   MISO     - serial data out, MSB first, registered
//   rx_data  - captured RX_W-bit frame for the RAM
//   rx_valid - one-cycle strobe qualifying rx_data
//   tx_data  - RAM read data
//   tx_valid - RAM read data valid
// A frame is: one command bit (0 = write, 1 = read) followed by RX_W frame bits.
// A read command goes to READ_ADD until an address frame has completed, then
// to READ_DATA, whose completion enables the return of one byte on MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int RX_W = SPI_RX_W,
    parameter int TX_W = SPI_TX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam int CNT_W = $clog2(RX_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(RX_W);

    spi_state_e       state_q;
    logic [RX_W-1:0]  shift_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [RX_W-1:0]  rx_data_q;
    logic             rx_valid_q;
    logic             rd_addr_seen_q;

    logic frame_done;
    logic tx_load_en;

    // bit_cnt parks at RX_W once the frame is captured, so further MOSI is ignored.
    assign frame_done = (bit_cnt_q == DONE_CNT);
    assign tx_load_en = (state_q == READ_DATA) && frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (SS_n) begin
                // Deselect ends the frame; a partial frame leaves no trace.
                state_q   <= IDLE;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= CHK_CMD;
                    CHK_CMD: begin
                        if (!MOSI)               state_q <= WRITE;
                        else if (rd_addr_seen_q) state_q <= READ_DATA;
                        else                     state_q <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!frame_done) begin
                            shift_q   <= {shift_q[RX_W-2:0], MOSI};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                rx_data_q  <= {shift_q[RX_W-2:0], MOSI};
                                rx_valid_q <= 1'b1;
                                if (state_q == READ_ADD)  rd_addr_seen_q <= 1'b1;
                                if (state_q == READ_DATA) rd_addr_seen_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .TX_W (TX_W)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (SS_n),
        .load_en_i  (tx_load_en),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .miso_o     (MISO)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks = 0;
    int errors = 0;

    spi_slave dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cmd;
        logic [9:0] frame;
        logic [2:0] st;
        logic       seen;
        logic       tx_en;
        logic [7:0] tx_byte;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives E0..E12 of a frame; tx_valid is pulsed at edge number stray_at.
    task automatic send_frame(input logic cmd, input logic [9:0] frame, input logic [2:0] exp_st,
                              input logic exp_seen, input int stray_at, input string tag);
        SS_n = 1'b0;
        tx_valid = (stray_at == 0);
        step();
        chk({tag, " E0 rx_valid"}, 32'(rx_valid), 0);
        MOSI = cmd;
        tx_valid = (stray_at == 1);
        step();
        chk({tag, " state"}, 32'(dut.state_q), 32'(exp_st));
        for (int i = 9; i >= 0; i--) begin
            MOSI = frame[i];
            tx_valid = (stray_at == 11 - i);
            step();
            chk({tag, " MISO in frame"}, 32'(MISO), 0);
            if (i != 0) chk({tag, " early rx_valid"}, 32'(rx_valid), 0);
        end
        tx_valid = 1'b0;
        chk({tag, " E11 rx_valid"}, 32'(rx_valid), 1);
        chk({tag, " rx_data"}, 32'(rx_data), 32'(frame));
        chk({tag, " rd_addr_seen"}, 32'(dut.rd_addr_seen_q), 32'(exp_seen));
        MOSI = ~MOSI;
        step();
        chk({tag, " E12 rx_valid"}, 32'(rx_valid), 0);
        chk({tag, " E12 MISO"}, 32'(MISO), 0);
    endtask

    // Caller has set tx_valid/tx_data before the load edge.
    task automatic serial_check(input logic [7:0] b, input string tag);
        step();
        tx_valid = 1'b0;
        chk({tag, " MISO b7"}, 32'(MISO), 32'(b[7]));
        for (int k = 6; k >= 0; k--) begin
            step();
            chk({tag, " MISO bit"}, 32'(MISO), 32'(b[k]));
        end
        step();
        chk({tag, " MISO after"}, 32'(MISO), 0);
    endtask

    task automatic end_frame(input string tag);
        SS_n = 1'b1;
        MOSI = 1'b0;
        step();
        chk({tag, " idle state"}, 32'(dut.state_q), 32'(IDLE));
        chk({tag, " idle MISO"}, 32'(MISO), 0);
    endtask

    initial begin
        logic [7:0] exp_b;

        vecs[0] = '{1'b0, {OP_WR_ADDR, 8'hA5}, 3'(WRITE),     1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, {OP_WR_DATA, 8'h3C}, 3'(WRITE),     1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, {OP_RD_ADDR, 8'hA5}, 3'(READ_ADD),  1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b1, {OP_RD_DATA, 8'h00}, 3'(READ_DATA), 1'b0, 1'b1, 8'hC3};
        vecs[4] = '{1'b1, 10'h2FF,             3'(READ_ADD),  1'b1, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 10'h100,             3'(WRITE),     1'b1, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 10'h3FF,             3'(READ_DATA), 1'b0, 1'b1, 8'h5A};

        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        step();
        step();
        chk("reset state", 32'(dut.state_q), 32'(IDLE));
        chk("reset MISO", 32'(MISO), 0);
        chk("reset rx_data", 32'(rx_data), 0);
        chk("reset rx_valid", 32'(rx_valid), 0);
        chk("reset rd_addr_seen", 32'(dut.rd_addr_seen_q), 0);
        rst = 1'b0;
        step();
        chk("idle hold", 32'(dut.state_q), 32'(IDLE));

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].cmd, vecs[v].frame, vecs[v].st, vecs[v].seen, -1, $sformatf("vec%0d", v));
            if (vecs[v].tx_en) begin
                tx_data = vecs[v].tx_byte;
                tx_valid = 1'b1;
                serial_check(vecs[v].tx_byte, $sformatf("vec%0d", v));
            end
            end_frame($sformatf("vec%0d", v));
        end

        // Abort a WRITE frame after E6, then a full frame must still decode.
        SS_n = 1'b0; step();
        MOSI = 1'b0; step();
        for (int i = 0; i < 5; i++) begin
            MOSI = i[0];
            step();
        end
        SS_n = 1'b1;
        step();
        chk("abort state", 32'(dut.state_q), 32'(IDLE));
        chk("abort rx_valid", 32'(rx_valid), 0);
        chk("abort rd_addr_seen", 32'(dut.rd_addr_seen_q), 0);
        step();
        chk("abort rx_valid late", 32'(rx_valid), 0);
        send_frame(1'b0, 10'h0A5, 3'(WRITE), 1'b0, -1, "post-abort");
        end_frame("post-abort");

        // Abort a READ_ADD frame: rd_addr_seen must stay clear.
        SS_n = 1'b0; step();
        MOSI = 1'b1; step();
        step(); step(); step();
        SS_n = 1'b1;
        step();
        chk("rdadd abort seen", 32'(dut.rd_addr_seen_q), 0);
        chk("rdadd abort rx_valid", 32'(rx_valid), 0);

        // Reset in the middle of serialisation.
        send_frame(1'b1, 10'h2A5, 3'(READ_ADD), 1'b1, -1, "rst-rdadd");
        end_frame("rst-rdadd");
        send_frame(1'b1, 10'h300, 3'(READ_DATA), 1'b0, -1, "rst-rddata");
        tx_data = 8'hC3; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        chk("rst E13 MISO", 32'(MISO), 1);
        step();
        chk("rst E14 MISO", 32'(MISO), 1);
        step();
        chk("rst E15 MISO", 32'(MISO), 0);
        rst = 1'b1;
        step();
        chk("midrst MISO", 32'(MISO), 0);
        chk("midrst rx_data", 32'(rx_data), 0);
        chk("midrst state", 32'(dut.state_q), 32'(IDLE));
        chk("midrst rd_addr_seen", 32'(dut.rd_addr_seen_q), 0);
        step();
        chk("midrst MISO held", 32'(MISO), 0);
        rst = 1'b0; SS_n = 1'b1;
        step();
        send_frame(1'b1, 10'h2A5, 3'(READ_ADD), 1'b1, -1, "after-rst");
        rst = 1'b1;
        step();
        chk("rst clears seen", 32'(dut.rd_addr_seen_q), 0);
        rst = 1'b0; SS_n = 1'b1;
        step();
        send_frame(1'b1, 10'h2A5, 3'(READ_ADD), 1'b1, -1, "after-rst2");
        end_frame("after-rst2");

        // Stray tx_valid during and after a WRITE frame.
        tx_data = 8'hFF;
        send_frame(1'b0, 10'h1AA, 3'(WRITE), 1'b1, 7, "stray-wr");
        tx_valid = 1'b1;
        step();
        chk("stray-wr post MISO", 32'(MISO), 0);
        step();
        chk("stray-wr post MISO2", 32'(MISO), 0);
        tx_valid = 1'b0;
        end_frame("stray-wr");

        // Stray tx_valid at E5 of READ_DATA, then a second late pulse is ignored.
        tx_data = 8'hFF;
        send_frame(1'b1, 10'h3C3, 3'(READ_DATA), 1'b0, 5, "stray-rd");
        exp_b = 8'h81;
        tx_data = exp_b; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        chk("stray-rd b7", 32'(MISO), 32'(exp_b[7]));
        for (int k = 6; k >= 0; k--) begin
            if (k == 5) begin
                tx_data = 8'hFF;
                tx_valid = 1'b1;
            end
            step();
            tx_valid = 1'b0;
            chk("stray-rd bit", 32'(MISO), 32'(exp_b[k]));
        end
        step();
        chk("stray-rd after", 32'(MISO), 0);
        end_frame("stray-rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
